sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-requester arbiter (fetch + load/store) onto one shared SRAM-like port.
// Holds an accepted-but-not-yet-granted owner and tracks response order.
module sram_arbiter #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic        proto_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

   state_t          state;
   state_t          state_nx;
   logic            owner_d;
   logic            full;
   logic            accept;
   logic            pop;
   logic            head_d;
   logic [CW-1:0]   count;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [DEPTH-1:0] order;

   assign full = (count == FULL);

   // Owner selection, shared-port request and next state.
   always_comb begin
      state_nx = state;
      owner_d  = 1'b0;
      mem_req  = 1'b0;
      unique case (state)
         IDLE: begin
            if (!full) begin
               if (data_req) begin
                  owner_d = 1'b1;
                  mem_req = 1'b1;
               end else if (inst_req) begin
                  mem_req = 1'b1;
               end
            end
            if (mem_req && !mem_addr_ok)
               state_nx = owner_d ? HOLD_D : HOLD_I;
         end
         HOLD_I: begin
            mem_req = 1'b1;
            if (mem_addr_ok) state_nx = IDLE;
         end
         HOLD_D: begin
            owner_d = 1'b1;
            mem_req = 1'b1;
            if (mem_addr_ok) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign mem_wr    = owner_d & data_wr;
   assign mem_size  = owner_d ? data_size  : 2'd2;
   assign mem_wstrb = owner_d ? data_wstrb : 4'd0;
   assign mem_addr  = owner_d ? data_addr  : inst_addr;
   assign mem_wdata = owner_d ? data_wdata : 32'd0;

   assign accept       = mem_req & mem_addr_ok;
   assign inst_addr_ok = accept & ~owner_d;
   assign data_addr_ok = accept & owner_d;

   assign pop          = mem_data_ok & (count != '0);
   assign head_d       = order[rd_ptr];
   assign inst_data_ok = pop & ~head_d;
   assign data_data_ok = pop & head_d;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // Arbitration state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nx;
   end

   // Response-order FIFO: one owner bit per accepted request.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         order  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept) begin
            order[wr_ptr] <= owner_d;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Outstanding count; simultaneous push and pop cancel.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count <= '0;
      end else begin
         unique case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky flag for a response arriving with nothing outstanding.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                          proto_err <= 1'b0;
      else if (mem_data_ok && count == '0)  proto_err <= 1'b1;
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed vectors, response
// expectations queued by stimulus and checked by a negedge monitor.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;
   logic        proto_err;

   typedef struct packed {
      logic        is_data;
      logic [31:0] d;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   sram_arbiter #(.DEPTH(4)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic respond(input logic is_data, input logic [31:0] d);
      sb.push_back('{is_data: is_data, d: d});
      mem_data_ok = 1'b1;
      mem_rdata   = d;
      next();
      mem_data_ok = 1'b0;
   endtask

   // Monitor: every response the DUT presents must match the queue head.
   always @(negedge clk) begin
      if (inst_data_ok || data_data_ok) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: inst_ok %b data_ok %b none queued",
                     inst_data_ok, data_data_ok);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_data_ok", 32'(data_data_ok), 32'(e.is_data));
            chk("rsp_inst_ok", 32'(inst_data_ok), 32'(!e.is_data));
            chk("rsp_rdata", e.is_data ? data_rdata : inst_rdata, e.d);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t limit 100000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      inst_req = 0; inst_addr = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0;
      data_addr = 0; data_wdata = 0;
      mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
      chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
      chk("rst_proto", 32'(proto_err), 0);
      next();
      resetn = 1'b1;

      // Data wins a simultaneous request; fetch follows.
      next();
      inst_req = 1; inst_addr = 32'h1000;
      data_req = 1; data_addr = 32'h2000; data_wr = 1;
      data_size = 2; data_wstrb = 4'hf; data_wdata = 32'hdead;
      mem_addr_ok = 1;
      @(negedge clk);
      chk("pri_data_ok", 32'(data_addr_ok), 1);
      chk("pri_inst_ok", 32'(inst_addr_ok), 0);
      chk("pri_addr", mem_addr, 32'h2000);
      chk("pri_wr", 32'(mem_wr), 1);
      chk("pri_wdata", mem_wdata, 32'hdead);
      next();
      data_req = 0;
      @(negedge clk);
      chk("pri2_inst_ok", 32'(inst_addr_ok), 1);
      chk("pri2_addr", mem_addr, 32'h1000);
      chk("pri2_wr", 32'(mem_wr), 0);
      chk("pri2_size", 32'(mem_size), 2);
      chk("pri2_wstrb", 32'(mem_wstrb), 0);
      next();
      inst_req = 0; mem_addr_ok = 0;
      respond(1, 32'hA1);
      respond(0, 32'hA2);

      // Fetch is held without preemption while the port stalls.
      inst_req = 1; inst_addr = 32'h1C000000; data_wr = 0;
      @(negedge clk);
      chk("hold_c1_req", 32'(mem_req), 1);
      chk("hold_c1_addr", mem_addr, 32'h1C000000);
      next();
      data_req = 1; data_addr = 32'h3000;
      @(negedge clk);
      chk("hold_c2_addr", mem_addr, 32'h1C000000);
      chk("hold_c2_dok", 32'(data_addr_ok), 0);
      next();
      @(negedge clk);
      chk("hold_c3_addr", mem_addr, 32'h1C000000);
      next();
      mem_addr_ok = 1;
      @(negedge clk);
      chk("hold_acc_iok", 32'(inst_addr_ok), 1);
      chk("hold_acc_dok", 32'(data_addr_ok), 0);
      chk("hold_acc_addr", mem_addr, 32'h1C000000);
      next();
      inst_req = 0;
      @(negedge clk);
      chk("hold_d_ok", 32'(data_addr_ok), 1);
      chk("hold_d_addr", mem_addr, 32'h3000);
      next();
      data_req = 0; mem_addr_ok = 0;
      respond(0, 32'hB1);
      respond(1, 32'hB2);

      // Fill the order FIFO, stall, then resume after one response.
      inst_req = 1; inst_addr = 32'h40; mem_addr_ok = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("fill_iok", 32'(inst_addr_ok), 1);
         next();
      end
      @(negedge clk);
      chk("full_req", 32'(mem_req), 0);
      chk("full_iok", 32'(inst_addr_ok), 0);
      next();
      sb.push_back('{is_data: 1'b0, d: 32'hC1});
      mem_data_ok = 1; mem_rdata = 32'hC1;
      @(negedge clk);
      chk("full_pop_iok", 32'(inst_addr_ok), 0);
      next();
      mem_data_ok = 0;
      @(negedge clk);
      chk("resume_iok", 32'(inst_addr_ok), 1);
      next();
      inst_req = 0; mem_addr_ok = 0;
      for (int i = 0; i < 4; i++) respond(0, 32'hC2 + 32'(i));

      // Ordering D, I, D.
      mem_addr_ok = 1;
      data_req = 1; data_addr = 32'h10;
      @(negedge clk);
      chk("ord_d1", 32'(data_addr_ok), 1);
      next();
      data_req = 0; inst_req = 1;
      @(negedge clk);
      chk("ord_i", 32'(inst_addr_ok), 1);
      next();
      inst_req = 0; data_req = 1;
      @(negedge clk);
      chk("ord_d2", 32'(data_addr_ok), 1);
      next();
      data_req = 0; mem_addr_ok = 0;
      respond(1, 32'h11);
      respond(0, 32'h22);
      respond(1, 32'h33);

      // Response with nothing outstanding.
      mem_data_ok = 1; mem_rdata = 32'h99;
      @(negedge clk);
      chk("perr_no_ok", 32'({inst_data_ok, data_data_ok}), 0);
      next();
      mem_data_ok = 0;
      @(negedge clk);
      chk("perr_set", 32'(proto_err), 1);
      next();
      next();
      @(negedge clk);
      chk("perr_held", 32'(proto_err), 1);

      // Reset while holding a data request with two outstanding.
      resetn = 0;
      #1;
      chk("rst2_proto", 32'(proto_err), 0);
      next();
      resetn = 1;
      data_req = 1; data_addr = 32'h50; mem_addr_ok = 1;
      next();
      next();
      mem_addr_ok = 0;
      @(negedge clk);
      chk("hd_req", 32'(mem_req), 1);
      chk("hd_dok", 32'(data_addr_ok), 0);
      next();
      next();
      resetn = 0; data_req = 0;
      #1;
      chk("rst3_req", 32'(mem_req), 0);
      next();
      resetn = 1;
      @(negedge clk);
      chk("rst3_idle", 32'(mem_req), 0);
      next();
      mem_data_ok = 1;
      @(negedge clk);
      chk("rst3_no_ok", 32'({inst_data_ok, data_data_ok}), 0);
      next();
      mem_data_ok = 0;
      @(negedge clk);
      chk("rst3_perr", 32'(proto_err), 1);

      next();
      chk("sb_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
